// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state type, default device windows and helpers for mmio_stall_decoder
package mmio_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [31:0] DATA_BASE    = 32'h1001_0000;
    localparam logic [31:0] GPIO_BASE    = 32'h1001_0100;
    localparam logic [31:0] UART_BASE    = 32'h1001_0200;
    localparam logic [31:0] DEFAULT_MASK = 32'hFFFF_FF00;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// mmio_addr_match: per-window address compare, lowest index wins when windows overlap
module mmio_addr_match #(
    parameter int ADDR_LENGTH = 32,
    parameter int N_DEV       = 4,
    parameter int IDX_W       = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic [ADDR_LENGTH-1:0]       addr,
    input  logic [N_DEV*ADDR_LENGTH-1:0] base,
    input  logic [N_DEV*ADDR_LENGTH-1:0] mask,
    output logic                         hit,
    output logic [N_DEV-1:0]             onehot,
    output logic [IDX_W-1:0]             idx
);

    logic [N_DEV-1:0] raw;

    for (genvar i = 0; i < N_DEV; i++) begin : g_win
        assign raw[i] = (addr & mask[i*ADDR_LENGTH +: ADDR_LENGTH]) ==
                        (base[i*ADDR_LENGTH +: ADDR_LENGTH] & mask[i*ADDR_LENGTH +: ADDR_LENGTH]);
    end

    assign hit    = |raw;
    assign onehot = raw & (~raw + N_DEV'(1));

    // Scan from the top down so the lowest matching index is the one left standing
    always_comb begin
        idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--)
            if (raw[i]) idx = IDX_W'(i);
    end

endmodule

// File: rtl/mmio_stall_decoder.sv
// mmio_stall_decoder: data-port address decoder with per-device ready, wait-state stall, timeout and error reporting
module mmio_stall_decoder
    import mmio_pkg::*;
#(
    parameter int ADDR_LENGTH    = 32,
    parameter int DATA_LENGTH    = 32,
    parameter int N_DEV          = 4,
    parameter logic [N_DEV*ADDR_LENGTH-1:0] DEV_BASE = '0,
    parameter logic [N_DEV*ADDR_LENGTH-1:0] DEV_MASK = {N_DEV{ADDR_LENGTH'(DEFAULT_MASK)}},
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_re,
    input  logic                         cpu_we,
    input  logic [ADDR_LENGTH-1:0]       cpu_addr,
    input  logic [DATA_LENGTH-1:0]       cpu_wdata,
    output logic [DATA_LENGTH-1:0]       cpu_rdata,
    output logic                         cpu_stall,
    output logic                         cpu_err,
    output logic [N_DEV-1:0]             dev_sel,
    output logic                         dev_we,
    output logic [ADDR_LENGTH-1:0]       dev_addr,
    output logic [DATA_LENGTH-1:0]       dev_wdata,
    input  logic [N_DEV*DATA_LENGTH-1:0] dev_rdata,
    input  logic [N_DEV-1:0]             dev_ready,
    output logic [ADDR_LENGTH-1:0]       err_addr,
    output logic [7:0]                   err_count
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    state_t                 state, state_nx;
    logic [TO_WIDTH-1:0]    cnt;
    logic [ADDR_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0] wdata_q, rdata_q;
    logic                   we_q, err_q;
    logic [IDX_W-1:0]       idx_q;

    logic                   req, hit;
    logic [N_DEV-1:0]       onehot;
    logic [IDX_W-1:0]       idx;
    logic                   hit_ready, q_ready, timed_out;
    logic [DATA_LENGTH-1:0] hit_rdata, q_rdata;

    assign req       = cpu_re | cpu_we;
    assign hit_ready = dev_ready[idx];
    assign hit_rdata = dev_rdata[idx*DATA_LENGTH +: DATA_LENGTH];
    assign q_ready   = dev_ready[idx_q];
    assign q_rdata   = dev_rdata[idx_q*DATA_LENGTH +: DATA_LENGTH];
    assign timed_out = cnt == TO_WIDTH'(TIMEOUT_CYCLES);

    mmio_addr_match #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .N_DEV       (N_DEV),
        .IDX_W       (IDX_W)
    ) u_match (
        .addr   (cpu_addr),
        .base   (DEV_BASE),
        .mask   (DEV_MASK),
        .hit    (hit),
        .onehot (onehot),
        .idx    (idx)
    );

    // Next state: only a mapped device that is not ready yet opens a wait window
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req && hit && !hit_ready) ? WAIT : IDLE;
            WAIT:    state_nx = (q_ready || timed_out) ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: pass-through in IDLE, latched request in WAIT, buffered result in DONE; all quiet in reset
    always_comb begin
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        cpu_err   = 1'b0;
        dev_sel   = '0;
        dev_we    = 1'b0;
        dev_addr  = '0;
        dev_wdata = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        dev_sel   = onehot;
                        dev_we    = cpu_we;
                        dev_addr  = cpu_addr;
                        dev_wdata = cpu_wdata;
                        cpu_rdata = hit_ready ? hit_rdata : '0;
                        cpu_stall = !hit_ready;
                    end else begin
                        cpu_err = req;
                    end
                end
                WAIT: begin
                    dev_sel   = N_DEV'(1) << idx_q;
                    dev_we    = we_q;
                    dev_addr  = addr_q;
                    dev_wdata = wdata_q;
                    cpu_stall = 1'b1;
                end
                default: begin
                    cpu_rdata = rdata_q;
                    cpu_err   = err_q;
                end
            endcase
        end
    end

    // Registers: latch the stalled access, collect its result and keep the error log
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req && hit && !hit_ready) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        we_q    <= cpu_we;
                        idx_q   <= idx;
                        cnt     <= TO_WIDTH'(1);
                    end else if (req && !hit) begin
                        err_addr  <= cpu_addr;
                        err_count <= sat_inc8(err_count);
                    end
                end
                WAIT: begin
                    if (q_ready) begin
                        rdata_q <= q_rdata;
                    end else if (timed_out) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        err_addr  <= addr_q;
                        err_count <= sat_inc8(err_count);
                    end else begin
                        cnt <= cnt + TO_WIDTH'(1);
                    end
                end
                default: begin
                    err_q <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_stall_decoder.sv
// tb_mmio_stall_decoder: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_mmio_stall_decoder;

    localparam int TO = 8;
    localparam logic [31:0] BASE [4] = '{32'h1001_0000, 32'h1001_0100, 32'h1001_0200, 32'h1001_0000};
    localparam logic [31:0] MASK [4] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000};
    localparam logic [127:0] P_BASE = {BASE[3], BASE[2], BASE[1], BASE[0]};
    localparam logic [127:0] P_MASK = {MASK[3], MASK[2], MASK[1], MASK[0]};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_err;
    logic [3:0]  dev_sel;
    logic        dev_we;
    logic [31:0] dev_addr, dev_wdata;
    logic [31:0] rd [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [127:0] dev_rdata;
    logic [3:0]  dev_ready = '0;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;

    assign dev_rdata = {rd[3], rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    mmio_stall_decoder #(
        .ADDR_LENGTH    (32),
        .DATA_LENGTH    (32),
        .N_DEV          (4),
        .DEV_BASE       (P_BASE),
        .DEV_MASK       (P_MASK),
        .TIMEOUT_CYCLES (TO),
        .TO_WIDTH       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .dev_sel   (dev_sel),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_ready (dev_ready),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASK[i]) == (BASE[i] & MASK[i])) return i;
        return -1;
    endfunction

    // Transaction-level model: one outstanding access, its wait length, and a retire slot
    int          pend = -1;
    int          k = 0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        p_we = 1'b0;
    bit          retiring = 1'b0;
    bit          ret_err = 1'b0;
    logic [31:0] ret_data = '0;
    int          m_errs = 0;
    logic [31:0] m_err_addr = '0;
    int          m_commits = 0;
    int          d_commits = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= -1; k <= 0; retiring <= 1'b0; ret_err <= 1'b0; ret_data <= '0;
            m_errs <= 0; m_err_addr <= '0;
        end else if (retiring) begin
            retiring <= 1'b0;
        end else if (pend >= 0) begin
            if (dev_ready[pend]) begin
                retiring <= 1'b1; ret_err <= 1'b0; ret_data <= rd[pend]; pend <= -1;
            end else if (k == TO) begin
                retiring <= 1'b1; ret_err <= 1'b1; ret_data <= '0; pend <= -1;
                m_errs <= m_errs + 1; m_err_addr <= p_addr;
            end else begin
                k <= k + 1;
            end
        end else if (cpu_re | cpu_we) begin
            if (decode(cpu_addr) < 0) begin
                m_errs <= m_errs + 1; m_err_addr <= cpu_addr;
            end else if (!dev_ready[decode(cpu_addr)]) begin
                pend <= decode(cpu_addr); k <= 1;
                p_addr <= cpu_addr; p_wdata <= cpu_wdata; p_we <= cpu_we;
            end
        end
    end

    always @(negedge clk) begin
        int d;
        logic [31:0] e_rd, e_a, e_wd;
        logic e_st, e_er, e_we;
        logic [3:0] e_sel;
        e_rd = '0; e_a = '0; e_wd = '0; e_st = 1'b0; e_er = 1'b0; e_we = 1'b0; e_sel = '0;
        if (rst) begin
            if (retiring) begin
                e_rd = ret_data; e_er = ret_err;
            end else if (pend >= 0) begin
                e_st = 1'b1; e_sel = 4'(1 << pend); e_a = p_addr; e_wd = p_wdata; e_we = p_we;
            end else if (cpu_re | cpu_we) begin
                d = decode(cpu_addr);
                if (d < 0) e_er = 1'b1;
                else begin
                    e_sel = 4'(1 << d); e_a = cpu_addr; e_wd = cpu_wdata; e_we = cpu_we;
                    e_st = !dev_ready[d]; e_rd = dev_ready[d] ? rd[d] : '0;
                end
            end
        end
        chk("cpu_rdata", cpu_rdata, e_rd);
        chk("cpu_stall", cpu_stall, e_st);
        chk("cpu_err", cpu_err, e_er);
        chk("dev_sel", dev_sel, e_sel);
        chk("dev_we", dev_we, e_we);
        chk("dev_addr", dev_addr, e_a);
        chk("dev_wdata", dev_wdata, e_wd);
        chk("err_addr", err_addr, m_err_addr);
        chk("err_count", err_count, (m_errs > 255) ? 255 : m_errs);
        if (e_we && (e_sel & dev_ready) != 0) m_commits++;
        if (dev_we && (dev_sel & dev_ready) != 0) d_commits++;
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; dev_ready = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    // Holds one access until the stall drops; ready for device dev is raised on stall cycle ready_at
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] wd, input int dev,
                          input int ready_at, input bit scramble,
                          output int stalls, output logic [31:0] rdata, output logic err);
        int c;
        c = 0;
        stalls = 0;
        @(posedge clk);
        #1 cpu_re = !w; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
        dev_ready = (ready_at == 0) ? 4'(1 << dev) : 4'b0;
        @(negedge clk);
        while (cpu_stall && c < 50) begin
            chk("hold_addr", dev_addr, a);
            chk("hold_wdata", dev_wdata, wd);
            chk("hold_we", dev_we, w);
            stalls++;
            c++;
            @(posedge clk);
            #1 dev_ready = (c == ready_at) ? 4'(1 << dev) : 4'b0;
            if (scramble) begin
                cpu_addr = $urandom; cpu_wdata = $urandom; cpu_re = 1'($urandom); cpu_we = 1'($urandom);
            end
            @(negedge clk);
        end
        if (c >= 50) chk("stall_bound", c, 0);
        rdata = cpu_rdata;
        err = cpu_err;
        @(posedge clk);
        #1 cpu_re = 1'b0; cpu_we = 1'b0; dev_ready = '0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] off;
        off = $urandom;
        case ($urandom_range(0, 5))
            0: return mmio_pkg::DATA_BASE | {24'h0, off[7:2], 2'b00};
            1: return mmio_pkg::GPIO_BASE | {24'h0, off[7:2], 2'b00};
            2: return mmio_pkg::UART_BASE | {24'h0, off[7:2], 2'b00};
            3: return 32'h1001_0300 + {18'h0, off[13:2], 2'b00};
            4: return off;
            default: return 32'h2000_0000 | {20'h0, off[11:0]};
        endcase
    endfunction

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int st, c0;
        logic [31:0] r;
        logic e;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("reset_stall", cpu_stall, 0);
        chk("reset_sel", dev_sel, 0);
        chk("reset_err_count", err_count, 0);
        chk("reset_err_addr", err_addr, 0);
        chk("reset_rdata", cpu_rdata, 0);

        rd[0] = 32'h1234_5678;
        @(posedge clk);
        #1 cpu_re = 1'b1; cpu_addr = 32'h1001_0004; dev_ready = 4'b0001;
        @(negedge clk);
        chk("zw_rdata", cpu_rdata, 32'h1234_5678);
        chk("zw_stall", cpu_stall, 0);
        chk("zw_sel", dev_sel, 4'b0001);

        @(posedge clk);
        #1 cpu_addr = 32'h2000_0000; dev_ready = '0;
        @(negedge clk);
        chk("unmap_err", cpu_err, 1);
        chk("unmap_rdata", cpu_rdata, 0);
        chk("unmap_stall", cpu_stall, 0);
        @(posedge clk);
        #1 cpu_re = 1'b0;
        @(negedge clk);
        chk("unmap_err_addr", err_addr, 32'h2000_0000);
        chk("unmap_err_count", err_count, 1);
        chk("unmap_pulse", cpu_err, 0);

        rd[2] = 32'h0000_00A5;
        access(32'h1001_0208, 1'b0, 32'h0, 2, 2, 1'b0, st, r, e);
        chk("ws_stalls", st, 3);
        chk("ws_rdata", r, 32'hA5);
        chk("ws_err", e, 0);
        @(negedge clk);
        chk("ws_idle_stall", cpu_stall, 0);
        chk("ws_idle_sel", dev_sel, 0);

        c0 = d_commits;
        access(32'h1001_0400, 1'b1, 32'h41, 3, 2, 1'b1, st, r, e);
        chk("wr_stalls", st, 3);
        @(negedge clk);
        chk("wr_commits", d_commits - c0, 1);

        access(32'h1001_0104, 1'b0, 32'h0, 1, -1, 1'b0, st, r, e);
        chk("to_stalls", st, TO + 1);
        chk("to_err", e, 1);
        chk("to_rdata", r, 0);
        @(negedge clk);
        chk("to_err_addr", err_addr, 32'h1001_0104);
        chk("to_err_count", err_count, 2);

        rd[2] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 cpu_re = 1'b1; cpu_addr = 32'h1001_0200; dev_ready = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rmw_sel", dev_sel, 0);
        chk("rmw_stall", cpu_stall, 0);
        chk("rmw_err_count", err_count, 0);
        cpu_re = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        rd[0] = 32'hCAFE_0001;
        access(32'h1001_0010, 1'b0, 32'h0, 0, 0, 1'b0, st, r, e);
        chk("rmw_after_stalls", st, 0);
        chk("rmw_after_rdata", r, 32'hCAFE_0001);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 cpu_re = 1'b1; cpu_addr = 32'h2000_0000 + 32'(i * 4);
        end
        @(posedge clk);
        #1 cpu_re = 1'b0;
        @(negedge clk);
        chk("sat_err_count", err_count, 255);

        do_reset();
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            cpu_re    = ($urandom_range(0, 9) < 5);
            cpu_we    = ($urandom_range(0, 9) < 3);
            cpu_addr  = rand_addr();
            cpu_wdata = $urandom;
            for (int i = 0; i < 4; i++) begin
                rd[i] = $urandom;
                dev_ready[i] = ($urandom_range(0, 99) < 35);
            end
        end
        @(posedge clk);
        #1 cpu_re = 1'b0; cpu_we = 1'b0; dev_ready = '0;
        repeat (TO + 3) @(posedge clk);
        @(negedge clk);
        chk("commit_total", d_commits, m_commits);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
